// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target receiver.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        DATA     = 3'd3,
        DATA_ACK = 3'd4,
        IGNORE   = 3'd5
    } i2c_state_e;

    localparam logic [6:0] DEFAULT_LCD_ADDR = 7'h27;
    localparam logic       I2C_WRITE        = 1'b0;
    localparam logic       I2C_READ         = 1'b1;
    localparam logic [3:0] BITS_PER_BYTE    = 4'd8;

    // An address byte selects us only for a write to our own address.
    function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] own_addr);
        return (addr_byte[7:1] == own_addr) && (addr_byte[0] == I2C_WRITE);
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizer plus glitch filter for one open-drain bus line; idles high.
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic line_o
);
    import i2c_pkg::*;

    localparam int               CW       = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample_s;
    logic                   filt_q, filt_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    assign sample_s = sync_q[SYNC_STAGES-1];
    assign line_o   = filt_q;

    // Synchronizer chain, reset to the idle-high bus level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= line_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // The filtered level flips only after FILT_LEN disagreeing samples in a row.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sample_s != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sample_s;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Filter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_target_rx.sv
// I2C write-only target: address match, ACK generation and byte delivery.
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = DEFAULT_LCD_ADDR,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_start,
    output logic       rx_stop,
    output logic       addr_match,
    output logic       busy
);

    logic scl_f_s, sda_f_s;
    logic scl_prev_q, sda_prev_q;
    logic start_s, stop_s, scl_rise_s, scl_fall_s;

    i2c_state_e state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_start_q, rx_start_d;
    logic       rx_stop_q, rx_stop_d;
    logic       addr_match_q, addr_match_d;
    logic       busy_q, busy_d;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (scl_in),
        .line_o (scl_f_s)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .line_i (sda_in),
        .line_o (sda_f_s)
    );

    assign start_s    = scl_f_s & scl_prev_q & sda_prev_q & ~sda_f_s;
    assign stop_s     = scl_f_s & scl_prev_q & ~sda_prev_q & sda_f_s;
    assign scl_rise_s = scl_f_s & ~scl_prev_q;
    assign scl_fall_s = ~scl_f_s & scl_prev_q;

    // Previous filtered levels for edge and START/STOP detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_f_s;
            sda_prev_q <= sda_f_s;
        end
    end

    // Protocol FSM: bus conditions override any bit handling in the same cycle.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        sda_oe_d     = sda_oe_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rx_start_d   = 1'b0;
        rx_stop_d    = 1'b0;
        addr_match_d = addr_match_q;
        busy_d       = busy_q;
        if (start_s) begin
            rx_start_d   = 1'b1;
            busy_d       = 1'b1;
            sda_oe_d     = 1'b0;
            addr_match_d = 1'b0;
            bit_cnt_d    = 4'd0;
            state_d      = ADDR;
        end else if (stop_s) begin
            rx_stop_d    = 1'b1;
            busy_d       = 1'b0;
            sda_oe_d     = 1'b0;
            addr_match_d = 1'b0;
            bit_cnt_d    = 4'd0;
            state_d      = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ADDR, DATA: begin
                    if (scl_rise_s && (bit_cnt_q != BITS_PER_BYTE)) begin
                        shift_d   = {shift_q[6:0], sda_f_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall_s && (bit_cnt_q == BITS_PER_BYTE)) begin
                        if (state_q == DATA) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            sda_oe_d   = 1'b1;
                            state_d    = DATA_ACK;
                        end else if (addr_hit(shift_q, I2C_ADDR)) begin
                            sda_oe_d     = 1'b1;
                            addr_match_d = 1'b1;
                            state_d      = ADDR_ACK;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    // ACK is driven for one full SCL period, released on its falling edge.
                    if (scl_fall_s) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = DATA;
                    end else begin
                        sda_oe_d = 1'b1;
                    end
                end
                IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    sda_oe_d = 1'b0;
                    state_d  = IDLE;
                end
            endcase
        end
    end

    // FSM and output registers; reset releases SDA immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 4'd0;
            sda_oe_q     <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_start_q   <= 1'b0;
            rx_stop_q    <= 1'b0;
            addr_match_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            sda_oe_q     <= sda_oe_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_start_q   <= rx_start_d;
            rx_stop_q    <= rx_stop_d;
            addr_match_q <= addr_match_d;
            busy_q       <= busy_d;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_start   = rx_start_q;
    assign rx_stop    = rx_stop_q;
    assign addr_match = addr_match_q;
    assign busy       = busy_q;

endmodule
